rf_exec_sequencer: RTL and testbench
====================================

Name: rf_exec_sequencer

Overview:
- Multi-cycle operand-fetch / execute / write-back initiator that drives the 4-entry register file from the requesting side.
- Accepts one decoded instruction per valid/ready handshake.
- Presents source addresses to the file's two combinational read ports and samples the returned operands.
- Computes a 16-bit ALU result and issues a single-cycle write on the file's write port.
- Sits between the instruction decoder and the register file in the simple CPU datapath.

Parameters:
- WORD_SIZE, 16, data word width; matches the register file's word width.
- ADDR_W, 2, register address width (4 registers).
- IMM_W, 8, immediate field width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  decoder presents an instruction.
- in_ready  output  1  sequencer can accept an instruction.
- in_op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 NOT, 5 SHL, 6 ADI, 7 LHI.
- in_rd  input  ADDR_W  destination register.
- in_rs  input  ADDR_W  source register 1.
- in_rt  input  ADDR_W  source register 2.
- in_imm  input  IMM_W  immediate.
- rf_addr1  output  ADDR_W  to register file read address 1.
- rf_addr2  output  ADDR_W  to register file read address 2.
- rf_data1  input  WORD_SIZE  register file read data 1 (combinational).
- rf_data2  input  WORD_SIZE  register file read data 2 (combinational).
- rf_write  output  1  register file write enable.
- rf_addr3  output  ADDR_W  register file write address.
- rf_data3  output  WORD_SIZE  register file write data.
- done  output  1  one-cycle pulse when write-back is issued.
- zero  output  1  result of the last completed instruction was 0x0000.

Behaviour:
- One clock domain. Reset is synchronous and active-low, sampled on the rising edge of clk.
- Reset values:
  - state = IDLE; in_ready = 1.
  - rf_write = 0; done = 0; zero = 0.
  - rf_addr1 = rf_addr2 = rf_addr3 = 0; rf_data3 = 0.
  - All latched instruction and operand fields = 0.
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, latch op/rd/rs/rt/imm and go to READ.
  - in_ready is asserted only in IDLE.
- READ:
  - rf_addr1 = latched rs, rf_addr2 = latched rt, both registered outputs.
  - At the end of the cycle, latch rf_data1/rf_data2 into opA/opB. Go to EXEC.
- EXEC: compute the result into a register, then go to WB. All arithmetic is modulo 2^16; carry and overflow are discarded.
  - ADD: A+B.
  - SUB: A-B.
  - AND: A&B.
  - ORR: A|B.
  - NOT: ~A.
  - SHL: A<<1, LSB filled with 0.
  - ADI: A + sign-extended imm (bit 7 replicated into bits 15:8).
  - LHI: {imm, 8'h00}; operands are ignored.
- WB:
  - rf_write = 1, rf_addr3 = rd, rf_data3 = result, done = 1, for exactly one cycle.
  - zero updates with (result == 0) on the same edge.
  - Next state is IDLE.
- Latency: handshake accepted at edge T; rf_write/done are high during cycle T+3; the write commits at edge T+4.
- Throughput: one instruction per 4 cycles. in_valid held high in WB is not accepted until IDLE.
- Back-to-back dependency (rd of instruction N = rs of N+1): N+1's READ occurs after N's write commits, so it reads the new value. No forwarding is required.
- rd == rs / rd == rt: operands were latched in READ, so the write in WB is safe.
- Inputs are don't-care outside the accepting IDLE cycle; later changes do not affect the latched instruction.
- Reset mid-operation (any state):
  - Next edge returns to IDLE with rf_write = 0 and done = 0.
  - An in-flight instruction never writes.
- rf_write is never high outside WB. done and rf_write are identical.

Decomposition:
- Shared package holds:
  - WORD_SIZE, ADDR_W, IMM_W.
  - Opcode constants (OP_ADD..OP_LHI).
  - FSM state encoding (IDLE, READ, EXEC, WB).
- One sub-module: rf_exec_alu, purely combinational (op, A, B, imm -> result).
- FSM, latches and register file port drive stay in the top module.

Test Plan:
- Reset then idle: reset_n low for 2 cycles -> in_ready = 1, rf_write = 0, done = 0, zero = 0; with no in_valid, rf_write stays 0 for 20 cycles.
- LHI then ADI:
  - Issue LHI rd=1 imm=0x12 -> write R1 = 0x1200 in cycle T+3.
  - Then ADI rd=2 rs=1 imm=0xFF -> R2 = 0x11FF (sign-extended -1).
- ADD wrap and zero flag:
  - Preload R0 = 0xFFFF, R1 = 0x0001 via LHI/ADI sequences.
  - ADD rd=3 rs=0 rt=1 -> rf_data3 = 0x0000, zero = 1.
  - SUB rd=3 rs=1 rt=0 -> 0x0002, zero = 0.
- Dependency chain: ADD rd=1 rs=1 rt=1 issued 3 times from R1 = 0x0003 -> writes 0x0006, 0x000C, 0x0018; each READ returns the prior write.
- Handshake: in_valid held high continuously with 4 distinct instructions -> exactly 4 accepts, spaced 4 cycles apart; in_ready low in READ/EXEC/WB; one done pulse per instruction.
- Reset mid-operation: assert reset_n = 0 during EXEC of ADD rd=2 -> no rf_write; R2 unchanged; the next accepted instruction completes normally with latency 3.

Source files
------------

// File: rtl/rf_exec_sequencer_pkg.sv
// Shared widths, opcode encodings and FSM state encoding for the
// register-file execute sequencer and its ALU.
package rf_exec_sequencer_pkg;

    localparam int WORD_SIZE = 16;
    localparam int ADDR_W    = 2;
    localparam int IMM_W     = 8;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_ORR = 3'd3;
    localparam logic [2:0] OP_NOT = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_ADI = 3'd6;
    localparam logic [2:0] OP_LHI = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    function automatic logic [WORD_SIZE-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(WORD_SIZE-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/rf_exec_sequencer_alu.sv
// Combinational 16-bit ALU; all arithmetic wraps modulo 2^16.
module rf_exec_alu
    import rf_exec_sequencer_pkg::*;
(
    input  logic [2:0]           op_i,
    input  logic [WORD_SIZE-1:0] a_i,
    input  logic [WORD_SIZE-1:0] b_i,
    input  logic [IMM_W-1:0]     imm_i,
    output logic [WORD_SIZE-1:0] result_o
);

    // Opcode decode to result
    always_comb begin
        result_o = {WORD_SIZE{1'b0}};
        case (op_i)
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_ORR:  result_o = a_i | b_i;
            OP_NOT:  result_o = ~a_i;
            OP_SHL:  result_o = {a_i[WORD_SIZE-2:0], 1'b0};
            OP_ADI:  result_o = a_i + sext_imm(imm_i);
            OP_LHI:  result_o = {imm_i, {(WORD_SIZE-IMM_W){1'b0}}};
            default: result_o = {WORD_SIZE{1'b0}};
        endcase
    end

endmodule

// File: rtl/rf_exec_sequencer.sv
// Fetch/execute/write-back sequencer driving a 4-entry register file:
// one instruction per four cycles, every register-file port driven from flops.
module rf_exec_sequencer
    import rf_exec_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [ADDR_W-1:0]    in_rd,
    input  logic [ADDR_W-1:0]    in_rs,
    input  logic [ADDR_W-1:0]    in_rt,
    input  logic [IMM_W-1:0]     in_imm,
    output logic [ADDR_W-1:0]    rf_addr1,
    output logic [ADDR_W-1:0]    rf_addr2,
    input  logic [WORD_SIZE-1:0] rf_data1,
    input  logic [WORD_SIZE-1:0] rf_data2,
    output logic                 rf_write,
    output logic [ADDR_W-1:0]    rf_addr3,
    output logic [WORD_SIZE-1:0] rf_data3,
    output logic                 done,
    output logic                 zero
);

    state_e               state_q;
    logic [2:0]           op_q;
    logic [ADDR_W-1:0]    rd_q;
    logic [IMM_W-1:0]     imm_q;
    logic [WORD_SIZE-1:0] opa_q;
    logic [WORD_SIZE-1:0] opb_q;
    logic                 in_ready_q;
    logic                 rf_write_q;
    logic                 zero_q;
    logic [ADDR_W-1:0]    rf_addr1_q;
    logic [ADDR_W-1:0]    rf_addr2_q;
    logic [ADDR_W-1:0]    rf_addr3_q;
    logic [WORD_SIZE-1:0] rf_data3_q;
    logic [WORD_SIZE-1:0] alu_result_s;

    rf_exec_alu u_alu (
        .op_i     (op_q),
        .a_i      (opa_q),
        .b_i      (opb_q),
        .imm_i    (imm_q),
        .result_o (alu_result_s)
    );

    // Sequencer FSM with instruction/operand latches and register-file port drive
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            op_q       <= 3'd0;
            rd_q       <= {ADDR_W{1'b0}};
            imm_q      <= {IMM_W{1'b0}};
            opa_q      <= {WORD_SIZE{1'b0}};
            opb_q      <= {WORD_SIZE{1'b0}};
            in_ready_q <= 1'b1;
            rf_write_q <= 1'b0;
            zero_q     <= 1'b0;
            rf_addr1_q <= {ADDR_W{1'b0}};
            rf_addr2_q <= {ADDR_W{1'b0}};
            rf_addr3_q <= {ADDR_W{1'b0}};
            rf_data3_q <= {WORD_SIZE{1'b0}};
        end else begin
            rf_write_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q       <= in_op;
                        rd_q       <= in_rd;
                        imm_q      <= in_imm;
                        rf_addr1_q <= in_rs;
                        rf_addr2_q <= in_rt;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_READ;
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    opa_q   <= rf_data1;
                    opb_q   <= rf_data2;
                    state_q <= ST_EXEC;
                end
                // Result lands in the write-port registers so WB drives them straight from flops
                ST_EXEC: begin
                    rf_write_q <= 1'b1;
                    rf_addr3_q <= rd_q;
                    rf_data3_q <= alu_result_s;
                    zero_q     <= (alu_result_s == {WORD_SIZE{1'b0}});
                    state_q    <= ST_WB;
                end
                ST_WB: begin
                    in_ready_q <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    in_ready_q <= 1'b1;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign rf_addr1 = rf_addr1_q;
    assign rf_addr2 = rf_addr2_q;
    assign rf_write = rf_write_q;
    assign rf_addr3 = rf_addr3_q;
    assign rf_data3 = rf_data3_q;
    assign done     = rf_write_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_rf_exec_sequencer.sv
// Directed bench: a behavioural 4-entry register file around the sequencer,
// with hand-computed expected results checked by immediate assertions.
module tb_rf_exec_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [1:0]  in_rd, in_rs, in_rt;
    logic [7:0]  in_imm;
    logic [1:0]  rf_addr1, rf_addr2, rf_addr3;
    logic [15:0] rf_data1, rf_data2, rf_data3;
    logic        rf_write, done, zero;

    logic [15:0] regs [4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Behavioural register file: combinational reads, write on rising edge
    always @(posedge clk) begin
        if (rf_write) regs[rf_addr3] <= rf_data3;
    end
    assign rf_data1 = regs[rf_addr1];
    assign rf_data2 = regs[rf_addr2];

    rf_exec_sequencer dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_rd    (in_rd),
        .in_rs    (in_rs),
        .in_rt    (in_rt),
        .in_imm   (in_imm),
        .rf_addr1 (rf_addr1),
        .rf_addr2 (rf_addr2),
        .rf_data1 (rf_data1),
        .rf_data2 (rf_data2),
        .rf_write (rf_write),
        .rf_addr3 (rf_addr3),
        .rf_data3 (rf_data3),
        .done     (done),
        .zero     (zero)
    );

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [1:0] rt, input logic [7:0] imm);
        in_op  = op;
        in_rd  = rd;
        in_rs  = rs;
        in_rt  = rt;
        in_imm = imm;
    endtask

    // Called at a negedge while idle; returns at the negedge of the following idle cycle
    task automatic run_instr(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                             input logic [1:0] rt, input logic [7:0] imm,
                             input logic [15:0] exp, input string tag);
        int lat;
        drive(op, rd, rs, rt, imm);
        in_valid = 1'b1;
        chk(in_ready, 1, {tag, "_ready"});
        @(posedge clk); #1;
        in_valid = 1'b0;
        drive(~op, ~rd, ~rs, ~rt, ~imm);
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            chk(in_ready, 0, {tag, "_busy"});
            if (rf_write) lat = k;
        end
        chk(lat, 3, {tag, "_latency"});
        chk(done, 1, {tag, "_done"});
        chk(rf_addr3, rd, {tag, "_addr3"});
        chk(rf_data3, exp, {tag, "_data3"});
        @(negedge clk);
        chk(rf_write, 0, {tag, "_wr_pulse"});
        chk(done, 0, {tag, "_done_pulse"});
        chk(in_ready, 1, {tag, "_ready_back"});
        chk(regs[rd], exp, {tag, "_regfile"});
        chk(zero, (exp == 16'h0000), {tag, "_zero"});
    endtask

    logic [2:0]  hs_op  [4] = '{3'd7, 3'd0, 3'd1, 3'd4};
    logic [1:0]  hs_rd  [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
    logic [1:0]  hs_rs  [4] = '{2'd0, 2'd2, 2'd3, 2'd0};
    logic [1:0]  hs_rt  [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic [7:0]  hs_imm [4] = '{8'h34, 8'h00, 8'h00, 8'h00};
    logic [15:0] hs_exp [4] = '{16'h3400, 16'h3418, 16'h0018, 16'hFFE7};

    initial begin
        int wr_cnt;
        int accepts;
        int dones;
        int idx;
        int overlap;
        int acc_cyc [4];
        logic accepted;

        reset_n  = 1'b0;
        in_valid = 1'b0;
        drive(3'd0, 2'd0, 2'd0, 2'd0, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk(in_ready, 1, "rst_ready");
        chk(rf_write, 0, "rst_write");
        chk(done, 0, "rst_done");
        chk(zero, 0, "rst_zero");
        chk({rf_addr1, rf_addr2, rf_addr3}, 0, "rst_addrs");
        chk(rf_data3, 0, "rst_data3");
        reset_n = 1'b1;

        wr_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rf_write) wr_cnt++;
        end
        chk(wr_cnt, 0, "idle_no_write");

        run_instr(3'd7, 2'd1, 2'd0, 2'd0, 8'h12, 16'h1200, "lhi_r1");
        run_instr(3'd6, 2'd2, 2'd1, 2'd0, 8'hFF, 16'h11FF, "adi_neg");

        run_instr(3'd7, 2'd0, 2'd0, 2'd0, 8'hFF, 16'hFF00, "pre_r0_a");
        run_instr(3'd6, 2'd0, 2'd0, 2'd0, 8'h7F, 16'hFF7F, "pre_r0_b");
        run_instr(3'd6, 2'd0, 2'd0, 2'd0, 8'h7F, 16'hFFFE, "pre_r0_c");
        run_instr(3'd6, 2'd0, 2'd0, 2'd0, 8'h01, 16'hFFFF, "pre_r0_d");
        run_instr(3'd7, 2'd1, 2'd0, 2'd0, 8'h00, 16'h0000, "pre_r1_a");
        run_instr(3'd6, 2'd1, 2'd1, 2'd0, 8'h01, 16'h0001, "pre_r1_b");

        run_instr(3'd0, 2'd3, 2'd0, 2'd1, 8'h00, 16'h0000, "add_wrap");
        run_instr(3'd1, 2'd3, 2'd1, 2'd0, 8'h00, 16'h0002, "sub_wrap");

        run_instr(3'd4, 2'd3, 2'd2, 2'd0, 8'h00, 16'hEE00, "not_op");
        run_instr(3'd3, 2'd3, 2'd3, 2'd1, 8'h00, 16'hEE01, "orr_op");
        run_instr(3'd2, 2'd3, 2'd3, 2'd2, 8'h00, 16'h0001, "and_op");
        run_instr(3'd5, 2'd3, 2'd2, 2'd0, 8'h00, 16'h23FE, "shl_op");
        run_instr(3'd5, 2'd3, 2'd0, 2'd0, 8'h00, 16'hFFFE, "shl_msb");

        run_instr(3'd6, 2'd1, 2'd1, 2'd0, 8'h02, 16'h0003, "dep_init");
        run_instr(3'd0, 2'd1, 2'd1, 2'd1, 8'h00, 16'h0006, "dep_1");
        run_instr(3'd0, 2'd1, 2'd1, 2'd1, 8'h00, 16'h000C, "dep_2");
        run_instr(3'd0, 2'd1, 2'd1, 2'd1, 8'h00, 16'h0018, "dep_3");

        // in_valid held high across four back-to-back instructions
        accepts = 0;
        dones   = 0;
        idx     = 0;
        overlap = 0;
        drive(hs_op[0], hs_rd[0], hs_rs[0], hs_rt[0], hs_imm[0]);
        in_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            accepted = 1'b0;
            if (rf_write) begin
                if (dones < 4) chk(rf_data3, hs_exp[dones], "hs_data");
                dones++;
            end
            if (in_ready && rf_write) overlap++;
            if (in_valid && in_ready) begin
                if (accepts < 4) acc_cyc[accepts] = c;
                accepts++;
                accepted = 1'b1;
            end
            @(posedge clk); #1;
            if (accepted) begin
                idx++;
                if (idx < 4) drive(hs_op[idx], hs_rd[idx], hs_rs[idx], hs_rt[idx], hs_imm[idx]);
                else in_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk(accepts, 4, "hs_accepts");
        chk(dones, 4, "hs_dones");
        chk(overlap, 0, "hs_ready_in_wb");
        if (accepts == 4) begin
            for (int i = 1; i < 4; i++) chk(acc_cyc[i] - acc_cyc[i-1], 4, "hs_spacing");
        end
        chk(regs[3], 16'h3418, "hs_r3");

        // Reset during EXEC of ADD rd=2 must suppress its write
        drive(3'd0, 2'd2, 2'd0, 2'd1, 8'h00);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk(rf_write, 0, "mid_rst_write");
        chk(done, 0, "mid_rst_done");
        chk(in_ready, 1, "mid_rst_ready");
        reset_n = 1'b1;
        wr_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rf_write) wr_cnt++;
        end
        chk(wr_cnt, 0, "mid_rst_no_write");
        chk(regs[2], 16'h3400, "mid_rst_r2_kept");
        run_instr(3'd6, 2'd2, 2'd2, 2'd0, 8'h01, 16'h3401, "post_rst_adi");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
